// File: rtl/processor_call_stack.sv
// processor_call_stack: resolves call/return redirects for fetch using a hardware return-address stack.
module processor_call_stack #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int STACK_DEPTH_LOG2 = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        no_operation_in,
  input  logic [ADDR_SIZE-1:0]        ip_plus_one_in,
  input  logic                        is_call,
  input  logic [WORD_SIZE-1:0]        call_target,
  input  logic                        is_return,
  output logic                        call_performed,
  output logic [WORD_SIZE-1:0]        ip_to_call,
  output logic                        return_performed,
  output logic [WORD_SIZE-1:0]        ip_to_return,
  output logic [STACK_DEPTH_LOG2:0]   depth,
  output logic                        stack_overflow,
  output logic                        stack_underflow
);
  localparam int N = 1 << STACK_DEPTH_LOG2;
  logic [WORD_SIZE-1:0] stack_q [N];
  logic [STACK_DEPTH_LOG2:0] sp_q, sp_d;
  logic call_performed_q, call_performed_d, return_performed_q, return_performed_d;
  logic [WORD_SIZE-1:0] ip_to_call_q, ip_to_call_d, ip_to_return_q, ip_to_return_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic accept, do_call, do_ret, full, empty, push;
  logic [STACK_DEPTH_LOG2-1:0] rd_idx;
  // Slot right after a redirect is wrong-path, so it is squashed.
  always_comb begin
    accept = !stall && !no_operation_in && !call_performed_q && !return_performed_q;
    do_call = accept && is_call;
    do_ret = accept && is_return && !is_call;
    full = sp_q[STACK_DEPTH_LOG2];
    empty = sp_q == '0;
    push = do_call && !full;
    rd_idx = sp_q[STACK_DEPTH_LOG2-1:0] - STACK_DEPTH_LOG2'(1);
    sp_d = push ? sp_q + 1'b1 : (do_ret && !empty) ? sp_q - 1'b1 : sp_q;
    call_performed_d = stall ? call_performed_q : do_call;
    return_performed_d = stall ? return_performed_q : do_ret;
    ip_to_call_d = do_call ? call_target : ip_to_call_q;
    ip_to_return_d = do_ret ? (empty ? '0 : stack_q[rd_idx]) : ip_to_return_q;
    overflow_d = overflow_q | (do_call && full);
    underflow_d = underflow_q | (do_ret && empty);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q <= '0;
      call_performed_q <= 1'b0;
      return_performed_q <= 1'b0;
      ip_to_call_q <= '0;
      ip_to_return_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      call_performed_q <= call_performed_d;
      return_performed_q <= return_performed_d;
      ip_to_call_q <= ip_to_call_d;
      ip_to_return_q <= ip_to_return_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && push) stack_q[sp_q[STACK_DEPTH_LOG2-1:0]] <= WORD_SIZE'(ip_plus_one_in);
  end
  assign call_performed = call_performed_q;
  assign return_performed = return_performed_q;
  assign ip_to_call = ip_to_call_q;
  assign ip_to_return = ip_to_return_q;
  assign depth = sp_q;
  assign stack_overflow = overflow_q;
  assign stack_underflow = underflow_q;
endmodule

// File: doc/processor_call_stack.md
Name: processor_call_stack

Overview:
Resolves call and return instructions for the fetch stage and drives its redirect inputs: ip_to_call/call_performed and ip_to_return/return_performed.
- On a call it pushes the return address (the fetch stage's ip_plus_one_out) onto a hardware return-address stack.
- On a return it pops that address.
- Sits one stage behind fetch: consumes fetch outputs plus decoded call/return flags, and feeds redirects back to fetch.

Parameters:
ADDR_SIZE, 18, width of instruction addresses from fetch
WORD_SIZE, 18, width of redirect addresses
STACK_DEPTH_LOG2, 4, log2 of stack entries (default 16 entries)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline hold; same meaning as fetch's no_operation
no_operation_in  input  1  current slot is a bubble (fetch's no_operation_out)
ip_plus_one_in  input  ADDR_SIZE  return address of current instruction (fetch's ip_plus_one_out)
is_call  input  1  current instruction is a call
call_target  input  WORD_SIZE  call destination
is_return  input  1  current instruction is a return
call_performed  output  1  one-cycle redirect pulse to fetch
ip_to_call  output  WORD_SIZE  call destination for fetch
return_performed  output  1  one-cycle redirect pulse to fetch
ip_to_return  output  WORD_SIZE  popped return address
depth  output  STACK_DEPTH_LOG2+1  current number of stack entries
stack_overflow  output  1  sticky: a push was dropped
stack_underflow  output  1  sticky: a return hit an empty stack

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: sp=0, depth=0, call_performed=0, return_performed=0, ip_to_call=0, ip_to_return=0, stack_overflow=0, stack_underflow=0. Stack RAM contents are not reset.
- Request acceptance: a request is accepted in a cycle only when all of these hold:
  - stall is 0,
  - no_operation_in is 0,
  - call_performed and return_performed are both 0 (shadow squash).
  The shadow rule exists because the instruction following a redirecting instruction is wrong-path. Fetch annuls only from the next slot onward.
- Stall: while stall=1, all registers hold, including any asserted pulse. The pulse is delivered when stall drops; it then lasts exactly one unstalled cycle.
- Non-stalled cycle with no accepted request: call_performed and return_performed clear to 0. ip_to_call and ip_to_return hold their values.
- Accepted call (latency 1):
  - stack[sp] <= ip_plus_one_in, zero-extended to WORD_SIZE; sp <= sp+1.
  - Next cycle: call_performed=1, ip_to_call=call_target.
- Call while full (depth == 2^STACK_DEPTH_LOG2):
  - Push is discarded; sp and depth are unchanged; stack_overflow <= 1.
  - The call still redirects (call_performed=1 next cycle).
- Accepted return (latency 1):
  - If depth>0: sp <= sp-1; next cycle return_performed=1 and ip_to_return=stack[sp-1].
  - If depth==0: stack_underflow <= 1; return_performed=1 with ip_to_return=0 (reset vector); sp unchanged.
- is_call and is_return both high: the call has priority and the return is ignored. No error flag is set.
- Pulse exclusivity: call_performed and return_performed are never high in the same cycle.
- Sticky flags: stack_overflow and stack_underflow clear only on reset.
- Reset mid-operation: in-flight pulses are dropped and the stack is empty the next cycle.
- Stack read: may use registered-read RAM, provided the one-cycle latency above is met. depth equals sp.

Test Plan:
- Single call/return: call at ip 0x10 (ip_plus_one_in=0x11, call_target=0x200); 3 cycles later a return. Expect:
  - call_performed=1, ip_to_call=0x200 one cycle after the call, depth=1;
  - return_performed=1, ip_to_return=0x11 one cycle after the return, depth=0.
- Nesting: calls with return addresses 0x11, 0x21, 0x31, then three returns. Expect ip_to_return 0x31, 0x21, 0x11 in order, and depth 3→0.
- Overflow: 17 calls with STACK_DEPTH_LOG2=4.
  - Expect: depth saturates at 16, stack_overflow=1 after the 17th call, and the 17th call still pulses call_performed.
  - Then 16 returns yield the first 16 addresses in LIFO order.
- Underflow: a return after reset. Expect return_performed=1, ip_to_return=0, stack_underflow=1, depth=0.
- Shadow and bubble: is_call held high for 2 consecutive cycles. Expect exactly one push and one pulse. A call with no_operation_in=1 produces no effect.
- Stall and priority:
  - Call accepted, then stall=1 for 3 cycles: call_performed holds 1 throughout, then clears one cycle after stall drops.
  - is_call and is_return both high: behaves as a call only.
  - reset asserted mid-sequence: all outputs return to reset values.
